trace_req_queue: RTL
====================

Name: trace_req_queue

Overview:
- Sits directly downstream of the trace parser.
- Accepts one decoded trace request per handshake (arrival time, core, operation, address) and buffers it in an in-order FIFO.
- Releases each request to the memory-controller scheduler only once the internal simulation-time counter has reached that request's arrival time.
- Tracks the end-of-trace marker and reports when every request has drained.

Parameters:
DEPTH, 16, number of queue entries (power of 2, >=2)
ADDR_W, 34, request address width
TIME_W, 32, arrival-time and sim-time counter width
CORE_W, 4, core ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  parser presents a request
in_ready  out  1  queue can accept
in_time  in  TIME_W  request arrival time (CPU cycles)
in_core  in  CORE_W  requesting core
in_op  in  2  0=read, 1=write, 2=ifetch, 3=illegal
in_addr  in  ADDR_W  request address
in_last  in  1  qualifies in_valid: final trace request
out_valid  out  1  head request is eligible to issue
out_ready  in  1  scheduler takes head
out_time, out_core, out_op, out_addr  out  as input  head request fields
count  out  $clog2(DEPTH)+1  occupancy
sim_time  out  TIME_W  current simulation time
done  out  1  trace finished and queue drained
order_err  out  1  sticky: accepted in_time < previously accepted in_time
op_err  out  1  sticky: illegal op received

Behaviour:
- Reset is asynchronous and active-low (rst_n). Reset state: queue empty, count=0, sim_time=0, in_ready=1, out_valid=0, all out_* fields=0, done=0, order_err=0, op_err=0, FSM=RUN. Reset asserted mid-operation discards all entries immediately.
- sim_time:
  - Increments by 1 every cycle out of reset.
  - Saturates at all-ones; no wrap.
  - Time-skip: if the queue is non-empty, out_valid=0, and head time > sim_time+1, sim_time loads head time directly on the next cycle.
- Enqueue occurs when in_valid && in_ready.
  - in_ready = !full && (FSM==RUN).
  - A full queue rejects input even if a dequeue happens in the same cycle.
- Illegal op (3): the handshake completes, the entry is dropped (not stored), and op_err sets. in_last on that handshake is still honoured.
- Ordering: order_err sets if an accepted in_time < the last accepted in_time. The entry is still stored in order.
- Dequeue occurs when out_valid && out_ready.
  - out_valid = !empty && head.time <= sim_time.
  - out_* fields always show the head entry, registered from FIFO storage; they hold their last value when the queue is empty.
  - No fall-through: an entry enqueued at cycle N is visible at the head no earlier than cycle N+1.
- Simultaneous enqueue and dequeue (not full): count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. full/empty are derived from count.
- FSM:
  - RUN -> DRAIN on an accepted handshake with in_last=1.
  - DRAIN -> DONE when count==0.
  - DONE is held until reset.
  - done=1 only in DONE.
  - In DRAIN and DONE, in_ready=0.

Decomposition:
- Package trace_pkg:
  - op_e enum (OP_READ, OP_WRITE, OP_IFETCH, OP_ILLEGAL).
  - trace_req_t struct {time, core, op, addr}.
  - Default width localparams.
  - FSM state enum (ST_RUN, ST_DRAIN, ST_DONE).
- Sub-module sync_fifo: parameterised storage, pointers and count, with push/pop/full/empty. The top level adds time gating, sim_time, the FSM and the error flags.

Test Plan:
- Time gating: reset, enqueue {time=10, core=1, op=0, addr=0x1_0000_0040} at sim_time 2 with out_ready=1 -> time-skip makes out_valid rise on the cycle sim_time reaches 10; the request issues exactly once and count returns to 0.
- Full: enqueue 16 requests with time=0 and out_ready=0 -> count=16, in_ready=0, the 17th is held off. Then pulse out_ready one cycle -> count=15, in_ready=1 the next cycle.
- Simultaneous push/pop with count=5 -> count stays 5; FIFO order is preserved across pointer wrap after 40 mixed operations (compare against a scoreboard).
- Errors: send time=100, then time=50 -> order_err=1, both entries issue in order. Send op=3 -> op_err=1, count unchanged.
- End of trace: send 3 requests, the last with in_last=1 -> in_ready=0 immediately afterwards; done=1 one cycle after the final dequeue; further in_valid is ignored.
- Reset mid-operation: assert rst_n=0 with count=7 -> count=0, out_valid=0 and sim_time=0 asynchronously; the queue operates normally after release.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace request queue: op codes, request record, FSM states.
package trace_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 34;
    localparam int DEF_TIME_W = 32;
    localparam int DEF_CORE_W = 4;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    // "time" is a keyword, hence arr_time.
    typedef struct packed {
        logic [DEF_TIME_W-1:0] arr_time;
        logic [DEF_CORE_W-1:0] core;
        op_e                   op;
        logic [DEF_ADDR_W-1:0] addr;
    } trace_req_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_illegal(input logic [1:0] op);
        return op == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/trace_req_queue_if.sv
// Parser-side and scheduler-side handshakes of the trace request queue.
interface trace_req_queue_if
    import trace_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TIME_W = DEF_TIME_W,
    parameter int CORE_W = DEF_CORE_W
);
    logic              in_valid;
    logic              in_ready;
    logic [TIME_W-1:0] in_time;
    logic [CORE_W-1:0] in_core;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [TIME_W-1:0] out_time;
    logic [CORE_W-1:0] out_core;
    logic [1:0]        out_op;
    logic [ADDR_W-1:0] out_addr;

    // master drives requests in and takes them out; slave is the queue
    modport master (
        output in_valid, in_time, in_core, in_op, in_addr, in_last, out_ready,
        input  in_ready, out_valid, out_time, out_core, out_op, out_addr
    );
    modport slave (
        input  in_valid, in_time, in_core, in_op, in_addr, in_last, out_ready,
        output in_ready, out_valid, out_time, out_core, out_op, out_addr
    );
endinterface

// File: rtl/sync_fifo.sv
// In-order FIFO with a registered head word (no fall-through); caller never
// pushes when full nor pops when empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q, rd_d, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        rd_d    = rd_q + AW'(pop_i);
        wr_d    = wr_q + AW'(push_i);
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        head_d  = head_q;
        // Next head may be the word being written this very cycle.
        if (count_d != '0)
            head_d = (push_i && (rd_d == wr_q)) ? wdata_i : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign rdata_o = head_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/trace_req_queue.sv
// Buffers decoded trace requests and releases each one once sim_time has
// reached its arrival time; tracks end-of-trace and drain completion.
module trace_req_queue
    import trace_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TIME_W = DEF_TIME_W,
    parameter int CORE_W = DEF_CORE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    trace_req_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic [TIME_W-1:0]       sim_time,
    output logic                    done,
    output logic                    order_err,
    output logic                    op_err
);
    localparam int EW = TIME_W + CORE_W + 2 + ADDR_W;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] sim_time_q, sim_time_d, last_time_q, head_time;
    logic              order_err_q, op_err_q;
    logic [EW-1:0]     head;
    logic              full, empty, accept, push, pop, skip;
    logic [TIME_W:0]   sim_p1;

    assign bus.in_ready = !full && (state_q == ST_RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !is_illegal(bus.in_op);

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.in_time, bus.in_core, bus.in_op, bus.in_addr}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign head_time     = head[EW-1 -: TIME_W];
    assign bus.out_time  = head_time;
    assign bus.out_core  = head[ADDR_W+2 +: CORE_W];
    assign bus.out_op    = head[ADDR_W +: 2];
    assign bus.out_addr  = head[ADDR_W-1:0];
    assign bus.out_valid = !empty && (head_time <= sim_time_q);
    assign pop           = bus.out_valid && bus.out_ready;

    // Jump straight to a far-future head instead of idling towards it.
    always_comb begin
        sim_p1 = {1'b0, sim_time_q} + (TIME_W+1)'(1);
        skip   = !empty && !bus.out_valid && ({1'b0, head_time} > sim_p1);
        if (skip)
            sim_time_d = head_time;
        else if (&sim_time_q)
            sim_time_d = sim_time_q;
        else
            sim_time_d = sim_time_q + TIME_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sim_time_q  <= '0;
            last_time_q <= '0;
            order_err_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sim_time_q <= sim_time_d;
            if (accept) begin
                last_time_q <= bus.in_time;
                if (bus.in_time < last_time_q) order_err_q <= 1'b1;
                if (is_illegal(bus.in_op))     op_err_q    <= 1'b1;
            end
        end
    end

    assign sim_time  = sim_time_q;
    assign done      = (state_q == ST_DONE);
    assign order_err = order_err_q;
    assign op_err    = op_err_q;

endmodule
